// File: rtl/led_fade_if.sv
// led_fade interface: blinker level in, PWM LED drive and ramp status out.
interface led_fade_if #(
   parameter int PWM_BITS = 8
);
   logic                LVL_IN;
   logic                LED_OUT;
   logic [PWM_BITS-1:0] DUTY;
   logic                BUSY;

   modport master (
      output LVL_IN,
      input  LED_OUT,
      input  DUTY,
      input  BUSY
   );

   modport slave (
      input  LVL_IN,
      output LED_OUT,
      output DUTY,
      output BUSY
   );
endinterface

// File: rtl/led_fade.sv
// LED fader: PWM brightness ramp up/down following a synchronized on/off level.
// Define LED_FADE_GAMMA_EN for a registered squared (gamma) PWM compare value.
module led_fade #(
   parameter int PWM_BITS    = 8,
   parameter int STEP_CYCLES = 4096
) (
   input logic     CLK,
   input logic     RST,
   led_fade_if.slave bus
);
   localparam int TW = $clog2(STEP_CYCLES);
   localparam logic [PWM_BITS-1:0] MAX = '1;
   localparam logic [TW-1:0] RLD = TW'(STEP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_OFF,
      S_UP,
      S_ON,
      S_DOWN
   } state_t;

   state_t              state_q;
   logic                s1_q;
   logic                s2_q;
   logic [PWM_BITS-1:0] pwm_q;
   logic [PWM_BITS-1:0] duty_q;
   logic [TW-1:0]       tmr_q;
   logic                busy_q;
   logic                led_q;
   logic [PWM_BITS-1:0] cmp;

`ifdef LED_FADE_GAMMA_EN
   logic [2*PWM_BITS-1:0] sq_d;
   logic [PWM_BITS-1:0]   g_q;

   assign sq_d = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         g_q <= '0;
      end else begin
         g_q <= sq_d[2*PWM_BITS-1:PWM_BITS];
      end
   end

   assign cmp = g_q;
`else
   assign cmp = duty_q;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_OFF;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         pwm_q   <= '0;
         duty_q  <= '0;
         tmr_q   <= '0;
         busy_q  <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         s1_q  <= bus.LVL_IN;
         s2_q  <= s1_q;
         pwm_q <= pwm_q + 1'b1;

         unique case (state_q)
            S_OFF:   led_q <= 1'b0;
            S_ON:    led_q <= 1'b1;
            default: led_q <= (pwm_q < cmp);
         endcase

         // Reversal is tested first so it wins over a coincident step.
         unique case (state_q)
            S_OFF: begin
               duty_q <= '0;
               if (s2_q) begin
                  state_q <= S_UP;
                  busy_q  <= 1'b1;
                  tmr_q   <= RLD;
               end
            end
            S_UP: begin
               if (!s2_q) begin
                  state_q <= S_DOWN;
                  tmr_q   <= RLD;
               end else if (tmr_q == '0) begin
                  tmr_q <= RLD;
                  if (duty_q != MAX) begin
                     duty_q <= duty_q + 1'b1;
                  end
                  if (duty_q >= MAX - 1'b1) begin
                     state_q <= S_ON;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            S_ON: begin
               duty_q <= MAX;
               if (!s2_q) begin
                  state_q <= S_DOWN;
                  busy_q  <= 1'b1;
                  tmr_q   <= RLD;
               end
            end
            S_DOWN: begin
               if (s2_q) begin
                  state_q <= S_UP;
                  tmr_q   <= RLD;
               end else if (tmr_q == '0) begin
                  tmr_q <= RLD;
                  if (duty_q != '0) begin
                     duty_q <= duty_q - 1'b1;
                  end
                  if (duty_q <= {{(PWM_BITS-1){1'b0}}, 1'b1}) begin
                     state_q <= S_OFF;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            default: state_q <= S_OFF;
         endcase
      end
   end

   assign bus.LED_OUT = led_q;
   assign bus.DUTY    = duty_q;
   assign bus.BUSY    = busy_q;
endmodule

// File: tb/tb_led_fade.sv
// Random and directed stimulus for led_fade against a cycle model of the
// ramp rules (sync delay, step age counter, PWM phase from cycle count).
module tb_led_fade;
   localparam int PB  = 4;
   localparam int SC  = 4;
   localparam int MX  = (1 << PB) - 1;
   localparam int PER = 1 << PB;

   localparam int M_OFF  = 0;
   localparam int M_RISE = 1;
   localparam int M_ON   = 2;
   localparam int M_FALL = 3;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   led_fade_if #(.PWM_BITS(PB)) bus ();

   led_fade #(
      .PWM_BITS   (PB),
      .STEP_CYCLES(SC)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   int m_mode;
   int m_duty;
   int m_age;
   int m_cyc;
   int m_led;
   int m_busy;
   int m_g;
   int lq[$];

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_OFF;
      m_duty = 0;
      m_age  = 0;
      m_cyc  = 0;
      m_led  = 0;
      m_busy = 0;
      m_g    = 0;
      lq     = '{0, 0};
   endtask

   // One clock edge of the reference behaviour, from pre-edge values.
   task automatic model_step();
      int ls;
      int cmpv;
      int nled;
      ls = lq.pop_front();
      lq.push_back(int'(bus.LVL_IN));
`ifdef LED_FADE_GAMMA_EN
      cmpv = m_g;
`else
      cmpv = m_duty;
`endif
      if (m_mode == M_ON) nled = 1;
      else if (m_mode == M_OFF) nled = 0;
      else nled = ((m_cyc % PER) < cmpv) ? 1 : 0;
      m_g = (m_duty * m_duty) >> PB;
      case (m_mode)
         M_OFF: if (ls == 1) begin
            m_mode = M_RISE;
            m_age  = 0;
         end
         M_ON: if (ls == 0) begin
            m_mode = M_FALL;
            m_age  = 0;
         end
         M_RISE: begin
            if (ls == 0) begin
               m_mode = M_FALL;
               m_age  = 0;
            end else begin
               m_age++;
               if (m_age == SC) begin
                  m_age = 0;
                  if (m_duty < MX) m_duty++;
                  if (m_duty == MX) m_mode = M_ON;
               end
            end
         end
         default: begin
            if (ls == 1) begin
               m_mode = M_RISE;
               m_age  = 0;
            end else begin
               m_age++;
               if (m_age == SC) begin
                  m_age = 0;
                  if (m_duty > 0) m_duty--;
                  if (m_duty == 0) m_mode = M_OFF;
               end
            end
         end
      endcase
      m_cyc++;
      m_led  = nled;
      m_busy = (m_mode == M_RISE || m_mode == M_FALL) ? 1 : 0;
   endtask

   task automatic tick();
      @(posedge CLK);
      if (!RST) model_step();
      @(negedge CLK);
      check("led", bus.LED_OUT, m_led);
      check("duty", bus.DUTY, m_duty);
      check("busy", bus.BUSY, m_busy);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int ok;
      int hold;
      bus.LVL_IN = 1'b0;
      model_reset();
      repeat (2) @(negedge CLK);
      check("rst_led", bus.LED_OUT, 0);
      check("rst_duty", bus.DUTY, 0);
      check("rst_busy", bus.BUSY, 0);
      RST = 1'b0;
      ticks(5);

      // Rise: BUSY appears on the third edge after the change.
      bus.LVL_IN = 1'b1;
      ticks(2);
      check("busy_c2", bus.BUSY, 0);
      tick();
      check("busy_c3", bus.BUSY, 1);
      ticks(70);
      check("on_duty", bus.DUTY, MX);
      check("on_busy", bus.BUSY, 0);
      check("on_led", bus.LED_OUT, 1);

      bus.LVL_IN = 1'b0;
      ticks(70);
      check("off_duty", bus.DUTY, 0);
      check("off_led", bus.LED_OUT, 0);

      // Collision: reversal lands on a step-expiry edge.
      bus.LVL_IN = 1'b1;
      ok = 0;
      for (int i = 0; i < 200 && ok == 0; i++) begin
         tick();
         if (m_mode == M_RISE && m_duty == 3 && m_age == 1) ok = 1;
      end
      check("coll_wait", ok, 1);
      bus.LVL_IN = 1'b0;
      ticks(3);
      check("coll_hold", bus.DUTY, 3);
      check("coll_busy", bus.BUSY, 1);
      ticks(3);
      check("coll_wait4", bus.DUTY, 3);
      tick();
      check("coll_step", bus.DUTY, 2);
      ticks(20);

      // Asynchronous reset mid-ramp at DUTY=7.
      bus.LVL_IN = 1'b1;
      ok = 0;
      for (int i = 0; i < 200 && ok == 0; i++) begin
         tick();
         if (m_mode == M_RISE && m_duty == 7) ok = 1;
      end
      check("rst7_wait", ok, 1);
      check("rst7_pre", bus.DUTY, 7);
      #2;
      RST = 1'b1;
      #1;
      check("arst_led", bus.LED_OUT, 0);
      check("arst_duty", bus.DUTY, 0);
      check("arst_busy", bus.BUSY, 0);
      model_reset();
      bus.LVL_IN = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      ticks(20);
      check("post_rst_duty", bus.DUTY, 0);
      check("post_rst_busy", bus.BUSY, 0);

      // Random level sequences, including short reversal pulses.
      for (int s = 0; s < 60; s++) begin
         bus.LVL_IN = 1'($urandom_range(0, 1));
         hold = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 80)
                                            : $urandom_range(1, 25);
         ticks(hold);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
